// File: rtl/output_port_sched.sv
// rtl/output_port_sched.sv - packet-level round-robin scheduler feeding decap_packet
//
// Arbitrates NUM_SRC first-word-fall-through input FIFOs, each holding whole DFX
// packets, onto the single Aurora frame path into decap_packet. One source is
// granted per packet. Its frames stream out for exactly FRAMES_PER_PKT cycles.
// The scheduler then waits for done_decap_pkt, or for a timeout, before it
// arbitrates again.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                arbitration enable (only gates new grants in IDLE)
//   src_req           per-source "FIFO holds a full packet"
//   src_data          per-source FWFT head frame, source i at [i*W +: W]
//   src_rd            per-source pop strobe
//   data_in_dfx       frame to decap_packet (0 when not strobing)
//   rd_output_port_0  decap frame-valid strobe
//   done_decap_pkt    decap completion pulse
//   grant             one-hot current owner, 0 when idle
//   busy              scheduler not in IDLE
//   err_timeout       one-cycle pulse when decap never completes
//   pkt_cnt           packets completed with done_decap_pkt (wraps)
module output_port_sched #(
   parameter int NUM_SRC           = 4,
   parameter int AURORA_DATA_WIDTH = 64,
   parameter int FRAMES_PER_PKT    = 19,
   parameter int TIMEOUT_CYC       = 64
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 en,
   input  logic [NUM_SRC-1:0]                   src_req,
   input  logic [NUM_SRC*AURORA_DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]                   src_rd,
   output logic [AURORA_DATA_WIDTH-1:0]         data_in_dfx,
   output logic                                 rd_output_port_0,
   input  logic                                 done_decap_pkt,
   output logic [NUM_SRC-1:0]                   grant,
   output logic                                 busy,
   output logic                                 err_timeout,
   output logic [15:0]                          pkt_cnt
);

   localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int BEAT_W = $clog2(FRAMES_PER_PKT + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

   localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(NUM_SRC - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAMES_PER_PKT - 1);
   localparam logic [TO_W-1:0]   LAST_TO   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_WAIT_DONE
   } state_t;

   state_t            state;
   logic [BEAT_W-1:0] beat_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [PTR_W-1:0]  rr_ptr;    // last port served; search starts just above it
   logic [PTR_W-1:0]  win_idx;   // port owning the current packet

   // Round-robin search: first requester strictly after rr_ptr, wrapping.
   // rr_ptr resets to NUM_SRC-1 so port 0 is checked first out of reset.
   logic             arb_found;
   logic [PTR_W-1:0] arb_idx;
   logic [PTR_W-1:0] cand_idx;
   int               cand;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         cand_idx = cand[PTR_W-1:0];
         if (!arb_found && src_req[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   // Once a packet is granted it always completes: src_req and en are only
   // looked at in IDLE, and done_decap_pkt only in WAIT_DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         grant            <= '0;
         rd_output_port_0 <= 1'b0;
         beat_cnt         <= '0;
         to_cnt           <= '0;
         rr_ptr           <= PTR_RST;
         win_idx          <= '0;
         err_timeout      <= 1'b0;
         pkt_cnt          <= '0;
      end else begin
         err_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (en && arb_found) begin
                  state            <= S_XFER;
                  grant            <= ONE_HOT0 << arb_idx;
                  win_idx          <= arb_idx;
                  rd_output_port_0 <= 1'b1;
                  beat_cnt         <= '0;
               end
            end
            S_XFER: begin
               if (beat_cnt == LAST_BEAT) begin
                  rd_output_port_0 <= 1'b0;
                  to_cnt           <= '0;
                  state            <= S_WAIT_DONE;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (done_decap_pkt) begin
                  state   <= S_IDLE;
                  grant   <= '0;
                  rr_ptr  <= win_idx;
                  pkt_cnt <= pkt_cnt + 16'd1;
               end else if (to_cnt == LAST_TO) begin
                  // Abort: the stuck port still becomes rr_ptr so it drops
                  // to lowest priority on the next arbitration.
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
                  grant       <= '0;
                  rr_ptr      <= win_idx;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state            <= S_IDLE;
               grant            <= '0;
               rd_output_port_0 <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = (state != S_IDLE);
   assign src_rd = grant & {NUM_SRC{rd_output_port_0}};

   always_comb begin
      data_in_dfx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i] && rd_output_port_0) begin
            data_in_dfx = src_data[i*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_output_port_sched.sv
// tb/tb_output_port_sched.sv - self-checking bench for output_port_sched
module tb_output_port_sched;

   localparam int N   = 4;
   localparam int W   = 64;
   localparam int FPP = 19;
   localparam int TO  = 64;

   logic           clk = 1'b0;
   logic           rst_n, en, done;
   logic [N-1:0]   src_req, src_rd, grant;
   logic [N*W-1:0] src_data;
   logic [W-1:0]   data_in_dfx;
   logic           rd, busy, err_timeout;
   logic [15:0]    pkt_cnt;

   int          total = 0;
   int          passed = 0;
   int          last_win;
   logic [15:0] exp_pkt;

   always #5 clk = ~clk;

   output_port_sched #(
      .NUM_SRC(N), .AURORA_DATA_WIDTH(W), .FRAMES_PER_PKT(FPP), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .src_req(src_req), .src_data(src_data),
      .src_rd(src_rd), .data_in_dfx(data_in_dfx), .rd_output_port_0(rd),
      .done_decap_pkt(done), .grant(grant), .busy(busy),
      .err_timeout(err_timeout), .pkt_cnt(pkt_cnt)
   );

   // Reference arbitration: first requester after the last winner, modulo N.
   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic randomize_data();
      for (int i = 0; i < N; i++) src_data[i*W +: W] = {$urandom, $urandom};
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; en = 1'b0; done = 1'b0; src_req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_win = N - 1;
      exp_pkt = '0;
   endtask

   task automatic wait_grant(input int budget, output int lat);
      lat = 0;
      while (lat < budget) begin
         @(negedge clk);
         lat++;
         if (grant != '0) break;
      end
   endtask

   // Walks one transfer from its first strobe; returns strobe count and the
   // number of beats whose pop/grant/data did not track the granted source.
   task automatic collect_xfer(input bit rand_data, input int hook_beat,
                               input logic [N-1:0] hook_req, input bit hook_done,
                               output int strobes, output int bad);
      logic [N-1:0] g0;
      g0 = grant; strobes = 0; bad = 0;
      while (rd === 1'b1 && strobes < 40) begin
         if (grant !== g0 || src_rd !== g0) bad++;
         for (int i = 0; i < N; i++)
            if (g0[i] && data_in_dfx !== src_data[i*W +: W]) bad++;
         done = 1'b0;
         if (strobes == hook_beat) begin
            src_req = hook_req;
            done = hook_done;
         end
         strobes++;
         if (rand_data) randomize_data();
         @(negedge clk);
      end
      done = 1'b0;
   endtask

   task automatic return_done(input int delay);
      repeat (delay) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; done = 1'b0; src_req = '0; src_data = '0;
      repeat (3) @(negedge clk);
      total++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0", grant); else passed++;
      total++; if (rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", rd); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else passed++;
      total++; if (pkt_cnt !== 16'd0) $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); else passed++;
      total++; if (src_rd !== '0 || data_in_dfx !== '0) $display("FAIL reset_datapath: got %b/%h want 0/0", src_rd, data_in_dfx); else passed++;
   endtask

   task automatic test_single();
      int lat, str, bad;
      apply_reset();
      randomize_data();
      src_data[0 +: W] = 64'hFFFFFFFFFFFFABCD;
      en = 1'b1; src_req = 4'b0001;
      wait_grant(5, lat);
      total++; if (lat != 1 || grant !== 4'b0001) $display("FAIL single_grant: got %b after %0d want 0001 after 1", grant, lat); else passed++;
      total++; if (data_in_dfx !== 64'hFFFFFFFFFFFFABCD) $display("FAIL single_data: got %h want FFFFFFFFFFFFABCD", data_in_dfx); else passed++;
      collect_xfer(1'b0, -1, '0, 1'b0, str, bad);
      total++; if (str != FPP) $display("FAIL single_strobes: got %0d want %0d", str, FPP); else passed++;
      total++; if (bad != 0) $display("FAIL single_beats: got %0d bad beats want 0", bad); else passed++;
      total++; if (rd !== 1'b0 || src_rd !== '0 || busy !== 1'b1 || data_in_dfx !== '0)
         $display("FAIL single_wait: got rd=%b src_rd=%b busy=%b data=%h want 0 0 1 0", rd, src_rd, busy, data_in_dfx); else passed++;
      src_req = '0;
      return_done(2);
      exp_pkt++; last_win = 0;
      total++; if (pkt_cnt !== exp_pkt) $display("FAIL single_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
      total++; if (busy !== 1'b0 || grant !== '0) $display("FAIL single_idle: got busy=%b grant=%b want 0 0", busy, grant); else passed++;
   endtask

   task automatic test_fairness();
      int lat, str, bad, w;
      apply_reset();
      en = 1'b1; src_req = 4'b1111; randomize_data();
      for (int p = 0; p < 5; p++) begin
         w = rr_pick(src_req, last_win);
         wait_grant(5, lat);
         total++; if (lat != 1 || grant !== 4'(1 << w)) $display("FAIL fair_grant%0d: got %b after %0d want %b after 1", p, grant, lat, 4'(1 << w)); else passed++;
         collect_xfer(1'b1, -1, '0, 1'b0, str, bad);
         total++; if (str != FPP || bad != 0) $display("FAIL fair_xfer%0d: got %0d strobes %0d bad want %0d 0", p, str, bad, FPP); else passed++;
         return_done(0);
         exp_pkt++; last_win = w;
      end
      total++; if (pkt_cnt !== exp_pkt) $display("FAIL fair_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
      src_req = '0;
   endtask

   task automatic test_mid_req();
      int lat, str, bad, w;
      src_req = 4'b0100;
      w = rr_pick(src_req, last_win);
      wait_grant(5, lat);
      total++; if (grant !== 4'(1 << w)) $display("FAIL mid_grant_a: got %b want %b", grant, 4'(1 << w)); else passed++;
      collect_xfer(1'b1, 5, 4'b0101, 1'b0, str, bad);
      total++; if (str != FPP || bad != 0) $display("FAIL mid_xfer_a: got %0d strobes %0d bad want %0d 0", str, bad, FPP); else passed++;
      return_done(1);
      exp_pkt++; last_win = w;
      w = rr_pick(src_req, last_win);
      wait_grant(5, lat);
      total++; if (grant !== 4'(1 << w)) $display("FAIL mid_grant_b: got %b want %b", grant, 4'(1 << w)); else passed++;
      collect_xfer(1'b1, -1, '0, 1'b0, str, bad);
      src_req = '0;
      return_done(0);
      exp_pkt++; last_win = w;
   endtask

   task automatic test_timeout();
      int lat, str, bad, cnt, w;
      src_req = 4'b0010;
      w = rr_pick(src_req, last_win);
      wait_grant(5, lat);
      total++; if (grant !== 4'b0010) $display("FAIL to_grant: got %b want 0010", grant); else passed++;
      collect_xfer(1'b1, -1, '0, 1'b0, str, bad);
      cnt = 0;
      while (err_timeout !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      total++; if (cnt != TO) $display("FAIL to_delay: got %0d cycles want %0d", cnt, TO); else passed++;
      total++; if (grant !== '0 || busy !== 1'b0) $display("FAIL to_idle: got grant=%b busy=%b want 0 0", grant, busy); else passed++;
      total++; if (pkt_cnt !== exp_pkt) $display("FAIL to_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
      last_win = w;
      src_req = 4'b0011;
      w = rr_pick(src_req, last_win);
      wait_grant(5, lat);
      total++; if (err_timeout !== 1'b0) $display("FAIL to_pulse: got %b want 0", err_timeout); else passed++;
      total++; if (grant !== 4'(1 << w)) $display("FAIL to_regrant: got %b want %b", grant, 4'(1 << w)); else passed++;
      collect_xfer(1'b1, -1, '0, 1'b0, str, bad);
      src_req = '0;
      return_done(0);
      exp_pkt++; last_win = w;
   endtask

   task automatic test_async_reset();
      int lat, str, bad;
      src_req = 4'b1111;
      wait_grant(5, lat);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (grant !== '0 || rd !== 1'b0 || src_rd !== '0 || busy !== 1'b0 || data_in_dfx !== '0)
         $display("FAIL arst_outputs: got grant=%b rd=%b src_rd=%b busy=%b want 0", grant, rd, src_rd, busy); else passed++;
      @(negedge clk);
      rst_n = 1'b1; last_win = N - 1; exp_pkt = '0;
      total++; if (pkt_cnt !== exp_pkt) $display("FAIL arst_pkt_cnt: got %0d want 0", pkt_cnt); else passed++;
      wait_grant(5, lat);
      total++; if (lat != 1 || grant !== 4'b0001) $display("FAIL arst_regrant: got %b after %0d want 0001 after 1", grant, lat); else passed++;
      collect_xfer(1'b1, -1, '0, 1'b0, str, bad);
      total++; if (str != FPP || bad != 0) $display("FAIL arst_xfer: got %0d strobes %0d bad want %0d 0", str, bad, FPP); else passed++;
      src_req = '0;
      return_done(0);
      exp_pkt++; last_win = 0;
   endtask

   task automatic test_en_gate();
      int lat, str, bad, wrong;
      en = 1'b0; src_req = 4'b1000; wrong = 0;
      repeat (20) begin
         @(negedge clk);
         if (grant !== '0 || busy !== 1'b0) wrong++;
      end
      total++; if (wrong != 0) $display("FAIL en_gate: got %0d granted cycles want 0", wrong); else passed++;
      en = 1'b1;
      wait_grant(5, lat);
      total++; if (lat != 1 || grant !== 4'b1000) $display("FAIL en_grant: got %b after %0d want 1000 after 1", grant, lat); else passed++;
      collect_xfer(1'b1, 7, 4'b1000, 1'b1, str, bad);
      total++; if (str != FPP || bad != 0) $display("FAIL en_done_in_xfer: got %0d strobes %0d bad want %0d 0", str, bad, FPP); else passed++;
      total++; if (busy !== 1'b1 || pkt_cnt !== exp_pkt) $display("FAIL en_wait: got busy=%b pkt=%0d want 1 %0d", busy, pkt_cnt, exp_pkt); else passed++;
      src_req = '0;
      return_done(0);
      exp_pkt++; last_win = 3;
      total++; if (pkt_cnt !== exp_pkt) $display("FAIL en_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
   endtask

   task automatic test_random();
      int lat, str, bad, w;
      for (int p = 0; p < 12; p++) begin
         src_req = 4'($urandom_range(1, 15));
         randomize_data();
         w = rr_pick(src_req, last_win);
         wait_grant(5, lat);
         total++; if (lat != 1 || grant !== 4'(1 << w)) $display("FAIL rand_grant%0d: req %b got %b want %b", p, src_req, grant, 4'(1 << w)); else passed++;
         collect_xfer(1'b1, $urandom_range(0, FPP - 1), 4'($urandom_range(0, 15)), 1'b0, str, bad);
         total++; if (str != FPP || bad != 0) $display("FAIL rand_xfer%0d: got %0d strobes %0d bad want %0d 0", p, str, bad, FPP); else passed++;
         return_done($urandom_range(0, 5));
         exp_pkt++; last_win = w;
         total++; if (pkt_cnt !== exp_pkt || busy !== 1'b0) $display("FAIL rand_done%0d: got pkt=%0d busy=%b want %0d 0", p, pkt_cnt, busy, exp_pkt); else passed++;
      end
      src_req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_mid_req();
      test_timeout();
      test_async_reset();
      test_en_gate();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
      $fatal(1);
   end

endmodule
